// File: rtl/memory_request_responder_pkg.sv
// Default sizing and width helpers shared by the memory request responder,
// its response queue and its bus interface.
package memory_request_responder_pkg;
    localparam int DefaultDataWidth      = 32;
    localparam int DefaultAddressBits    = 20;
    localparam int DefaultIndexBits      = 8;
    localparam int DefaultLatency        = 2;
    localparam int DefaultMaxOutstanding = 4;
    localparam int DefaultStallPeriod    = 0;

    // Bits needed to hold every value in 0..maxValue (never fewer than one).
    function automatic int bitsFor(input int maxValue);
        return (maxValue < 2) ? 1 : $clog2(maxValue + 1);
    endfunction
endpackage

// File: rtl/memory_request_responder_if.sv
// Core-to-memory request/response bundle; the core drives the master side,
// the responder sits on the slave side.
interface memory_request_responder_if
    import memory_request_responder_pkg::*;
#(
    parameter int DATA_WIDTH   = DefaultDataWidth,
    parameter int ADDRESS_BITS = DefaultAddressBits
) ();
    logic                    read;
    logic                    write;
    logic [ADDRESS_BITS-1:0] address;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    ready;
    logic                    valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [ADDRESS_BITS-1:0] out_address;

    modport master (
        output read, write, address, in_data,
        input  ready, valid, out_data, out_address
    );

    modport slave (
        input  read, write, address, in_data,
        output ready, valid, out_data, out_address
    );
endinterface

// File: rtl/memory_request_responder_response_queue.sv
// In-order circular buffer of pending read responses; every entry carries its
// own countdown so the head knows when its fixed latency has elapsed.
module memory_request_responder_response_queue
    import memory_request_responder_pkg::*;
#(
    parameter int DATA_WIDTH      = DefaultDataWidth,
    parameter int ADDRESS_BITS    = DefaultAddressBits,
    parameter int LATENCY         = DefaultLatency,
    parameter int MAX_OUTSTANDING = DefaultMaxOutstanding,
    localparam int CountBits      = bitsFor(MAX_OUTSTANDING),
    localparam int TimerBits      = bitsFor(LATENCY - 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [ADDRESS_BITS-1:0] pushAddress_i,
    input  logic [DATA_WIDTH-1:0]   pushData_i,
    input  logic                    pop_i,
    output logic [ADDRESS_BITS-1:0] headAddress_o,
    output logic [DATA_WIDTH-1:0]   headData_o,
    output logic [TimerBits-1:0]    headTimer_o,
    output logic [CountBits-1:0]    count_o
);
    localparam int PtrBits = bitsFor(MAX_OUTSTANDING - 1);
    localparam logic [TimerBits-1:0] StartTimer = TimerBits'(LATENCY - 1);

    logic [ADDRESS_BITS-1:0] entryAddress_q [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0]   entryData_q    [MAX_OUTSTANDING];
    logic [TimerBits-1:0]    entryTimer_q   [MAX_OUTSTANDING];
    logic [TimerBits-1:0]    entryTimer_d   [MAX_OUTSTANDING];
    logic [PtrBits-1:0]      headPtr_q, headPtr_d;
    logic [PtrBits-1:0]      tailPtr_q, tailPtr_d;
    logic [CountBits-1:0]    count_q, count_d;

    // All timers age every cycle, so a fresh push simply overrides its slot.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            entryTimer_d[i] = (entryTimer_q[i] != '0) ? entryTimer_q[i] - 1'b1 : '0;
        end
        if (push_i) begin
            entryTimer_d[tailPtr_q] = StartTimer;
            tailPtr_d               = tailPtr_q + 1'b1;
        end
        if (pop_i) begin
            headPtr_d = headPtr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                entryTimer_q[i] <= '0;
            end
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                entryTimer_q[i] <= entryTimer_d[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) begin
            entryAddress_q[tailPtr_q] <= pushAddress_i;
            entryData_q[tailPtr_q]    <= pushData_i;
        end
    end

    assign headAddress_o = entryAddress_q[headPtr_q];
    assign headData_o    = entryData_q[headPtr_q];
    assign headTimer_o   = entryTimer_q[headPtr_q];
    assign count_o       = count_q;
endmodule

// File: rtl/memory_request_responder.sv
// Memory-side responder: word-addressed storage, fixed-latency in-order read
// responses with address echo, and optional periodic ready stalls.
module memory_request_responder
    import memory_request_responder_pkg::*;
#(
    parameter int DATA_WIDTH      = DefaultDataWidth,
    parameter int ADDRESS_BITS    = DefaultAddressBits,
    parameter int INDEX_BITS      = DefaultIndexBits,
    parameter int LATENCY         = DefaultLatency,
    parameter int MAX_OUTSTANDING = DefaultMaxOutstanding,
    parameter int STALL_PERIOD    = DefaultStallPeriod
) (
    input logic                     clock,
    input logic                     reset,
    memory_request_responder_if.slave bus
);
    localparam int CountBits = bitsFor(MAX_OUTSTANDING);
    localparam int TimerBits = bitsFor(LATENCY - 1);

    logic [DATA_WIDTH-1:0]   mem [2**INDEX_BITS];
    logic [INDEX_BITS-1:0]   wordIndex;
    logic                    stallNow;
    logic                    ready;
    logic                    acceptRead;
    logic                    acceptWrite;
    logic                    retire;
    logic [CountBits-1:0]    count;
    logic [ADDRESS_BITS-1:0] headAddress;
    logic [DATA_WIDTH-1:0]   headData;
    logic [TimerBits-1:0]    headTimer;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   outData_q, outData_d;
    logic [ADDRESS_BITS-1:0] outAddress_q, outAddress_d;

    assign wordIndex = bus.address[INDEX_BITS+1:2];

    generate
        if (STALL_PERIOD > 0) begin : gStall
            localparam int StallBits = bitsFor(STALL_PERIOD - 1);
            localparam logic [StallBits-1:0] LastCount = StallBits'(STALL_PERIOD - 1);
            logic [StallBits-1:0] stallCount_q, stallCount_d;

            assign stallCount_d = (stallCount_q == LastCount) ? '0 : stallCount_q + 1'b1;
            assign stallNow     = (stallCount_q == LastCount);

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) stallCount_q <= '0;
                else        stallCount_q <= stallCount_d;
            end
        end else begin : gNoStall
            assign stallNow = 1'b0;
        end
    endgenerate

    // A retire in the same cycle deliberately does not reopen a full queue.
    assign ready       = reset & (count < CountBits'(MAX_OUTSTANDING)) & ~stallNow;
    assign acceptWrite = bus.write & ready;
    assign acceptRead  = bus.read & ~bus.write & ready;
    assign retire      = (count != '0) & (headTimer == '0);

    always_ff @(posedge clock) begin
        if (acceptWrite) mem[wordIndex] <= bus.in_data;
    end

    memory_request_responder_response_queue #(
        .DATA_WIDTH      (DATA_WIDTH),
        .ADDRESS_BITS    (ADDRESS_BITS),
        .LATENCY         (LATENCY),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) responseQueue (
        .clock         (clock),
        .reset         (reset),
        .push_i        (acceptRead),
        .pushAddress_i (bus.address),
        .pushData_i    (mem[wordIndex]),
        .pop_i         (retire),
        .headAddress_o (headAddress),
        .headData_o    (headData),
        .headTimer_o   (headTimer),
        .count_o       (count)
    );

    always_comb begin
        valid_d      = retire;
        outData_d    = outData_q;
        outAddress_d = outAddress_q;
        if (retire) begin
            outData_d    = headData;
            outAddress_d = headAddress;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            outData_q    <= '0;
            outAddress_q <= '0;
        end else begin
            valid_q      <= valid_d;
            outData_q    <= outData_d;
            outAddress_q <= outAddress_d;
        end
    end

    assign bus.ready       = ready;
    assign bus.valid       = valid_q;
    assign bus.out_data    = outData_q;
    assign bus.out_address = outAddress_q;
endmodule
